// File: rtl/sprite_eval.sv
// sprite_eval: per-line sprite evaluator. Scans the 64-entry attribute table
// one sprite per cycle, keeps up to MAX_SPR visible sprites for the requested
// line in scan order, then presents them through a valid/ready handshake.
module sprite_eval #(
  parameter int MAX_SPR = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  output logic [5:0]  spr_sel,
  input  logic [8:0]  spr_x,
  input  logic [7:0]  spr_y,
  input  logic [9:0]  spr_idx,
  input  logic        spr_priority,
  input  logic        spr_h16,
  input  logic        spr_vflip,
  input  logic        spr_hflip,
  input  logic [1:0]  spr_palette,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_x,
  output logic [9:0]  out_idx,
  output logic [2:0]  out_row,
  output logic [1:0]  out_palette,
  output logic        out_priority,
  output logic        out_hflip,
  output logic        out_last,
  output logic        busy,
  output logic        overflow,
  output logic        done
);

  // Count needs to reach MAX_SPR itself; pointers only address 0..MAX_SPR-1.
  localparam int CW = $clog2(MAX_SPR + 1);
  localparam int AW = (MAX_SPR > 1) ? $clog2(MAX_SPR) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_e;

  typedef struct packed {
    logic [8:0] x;
    logic [9:0] idx;
    logic [2:0] row;
    logic [1:0] palette;
    logic       priority_bit;
    logic       hflip;
  } entry_t;

  state_e          state_q, state_d;
  logic [7:0]      ly_q, ly_d;
  logic [5:0]      sel_q, sel_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  entry_t          list_q [MAX_SPR];
  entry_t          new_entry;
  entry_t          rd_entry;
  logic            wr_en;

  logic [7:0]      dy;
  logic            visible;
  logic            list_full;
  logic            last_entry;

  // Visibility test and stored-entry formatting for the sprite on spr_sel.
  always_comb begin
    dy                     = ly_q - spr_y;
    visible                = spr_h16 ? (dy < 8'd16) : (dy < 8'd8);
    new_entry.x            = spr_x;
    new_entry.row          = dy[2:0] ^ {3{spr_vflip}};
    new_entry.idx          = spr_idx + {9'd0, spr_h16 & (dy[3] ^ spr_vflip)};
    new_entry.palette      = spr_palette;
    new_entry.priority_bit = spr_priority;
    new_entry.hflip        = spr_hflip;
    list_full              = (count_q == CW'(MAX_SPR));
    last_entry             = (CW'(rd_ptr_q) == count_q - CW'(1));
  end

  // Datapath next-state: scan pointer, list fill, read pointer, flags.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    ly_d     = ly_q;
    sel_d    = sel_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    if (line_start) begin
      ly_d     = line_y;
      sel_d    = '0;
      count_d  = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (visible) begin
            if (list_full) begin
              ovf_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              count_d = count_q + CW'(1);
            end
          end
          if (sel_q != 6'd63) begin
            sel_d = sel_q + 6'd1;
          end else if (count_d == '0) begin
            done_d = 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_entry) done_d = 1'b1;
            else            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (line_start) begin
      state_d = SCAN;
    end else begin
      case (state_q)
        SCAN:    if (sel_q == 6'd63) state_d = (count_d != '0) ? EMIT : IDLE;
        EMIT:    if (out_ready && last_entry) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      state_q  <= IDLE;
      ly_q     <= '0;
      sel_q    <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ly_q     <= ly_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Sprite list storage, written at the current count during SCAN.
  always_ff @(posedge clk) begin
    // NOTE: the list has no reset; count and state gate every read, so stale data is never visible.
    if (wr_en) list_q[count_q[AW-1:0]] <= new_entry;
  end

  // FSM outputs: entry fields are forced to zero outside EMIT.
  always_comb begin
    rd_entry     = list_q[rd_ptr_q];
    busy         = (state_q != IDLE);
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_x        = '0;
    out_idx      = '0;
    out_row      = '0;
    out_palette  = '0;
    out_priority = 1'b0;
    out_hflip    = 1'b0;
    if (state_q == EMIT) begin
      out_valid    = 1'b1;
      out_last     = last_entry;
      out_x        = rd_entry.x;
      out_idx      = rd_entry.idx;
      out_row      = rd_entry.row;
      out_palette  = rd_entry.palette;
      out_priority = rd_entry.priority_bit;
      out_hflip    = rd_entry.hflip;
    end
  end

  assign spr_sel  = sel_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sprite_eval.sv
// Self-checking bench for sprite_eval: attribute-table model, table-driven
// single-sprite vectors, scoreboarded multi-sprite lines and corner sequences.
module tb_sprite_eval;
  localparam int MAX_SPR = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  line_y = '0;
  logic [5:0]  spr_sel;
  logic [8:0]  spr_x;
  logic [7:0]  spr_y;
  logic [9:0]  spr_idx;
  logic        spr_priority, spr_h16, spr_vflip, spr_hflip;
  logic [1:0]  spr_palette;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  out_x;
  logic [9:0]  out_idx;
  logic [2:0]  out_row;
  logic [1:0]  out_palette;
  logic        out_priority, out_hflip, out_last;
  logic        busy, overflow, done;

  always #5 clk = ~clk;

  sprite_eval #(.MAX_SPR(MAX_SPR)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
    .spr_sel(spr_sel), .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx),
    .spr_priority(spr_priority), .spr_h16(spr_h16), .spr_vflip(spr_vflip),
    .spr_hflip(spr_hflip), .spr_palette(spr_palette),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_idx(out_idx), .out_row(out_row), .out_palette(out_palette),
    .out_priority(out_priority), .out_hflip(out_hflip), .out_last(out_last),
    .busy(busy), .overflow(overflow), .done(done)
  );

  // Attribute table, read combinationally through spr_sel.
  logic [8:0] t_x   [64];
  logic [7:0] t_y   [64];
  logic [9:0] t_idx [64];
  logic [1:0] t_pal [64];
  logic       t_pri [64], t_h16 [64], t_vf [64], t_hf [64];

  assign spr_x        = t_x[spr_sel];
  assign spr_y        = t_y[spr_sel];
  assign spr_idx      = t_idx[spr_sel];
  assign spr_palette  = t_pal[spr_sel];
  assign spr_priority = t_pri[spr_sel];
  assign spr_h16      = t_h16[spr_sel];
  assign spr_vflip    = t_vf[spr_sel];
  assign spr_hflip    = t_hf[spr_sel];

  typedef struct packed {
    logic [8:0] x;
    logic [9:0] idx;
    logic [2:0] row;
    logic [1:0] pal;
    logic       pri;
    logic       hflip;
    logic       last;
  } ent_t;

  typedef struct {
    logic [7:0] ly;
    logic [7:0] y;
    logic       h16;
    logic       vflip;
    logic [9:0] idx;
    logic       vis;
    logic [2:0] row;
    logic [9:0] eidx;
  } vec_t;

  ent_t exp_q[$];
  logic exp_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t cur_ent();
    return {out_x, out_idx, out_row, out_palette, out_priority, out_hflip, out_last};
  endfunction

  // Every sprite far below the line; other attributes random.
  task automatic set_offline(input logic [7:0] ly);
    for (int s = 0; s < 64; s++) begin
      t_y[s]   = ly + 8'd64;
      t_h16[s] = 1'b0;
      t_vf[s]  = 1'($urandom);
      t_x[s]   = 9'($urandom);
      t_idx[s] = 10'($urandom);
      t_pal[s] = 2'($urandom);
      t_pri[s] = 1'($urandom);
      t_hf[s]  = 1'($urandom);
    end
  endtask

  // Reference model: expected list for line ly from the current table.
  task automatic model_line(input logic [7:0] ly);
    int hits[$];
    logic [7:0] dy;
    ent_t e;
    exp_ovf = 1'b0;
    for (int s = 0; s < 64; s++) begin
      dy = ly - t_y[s];
      if (t_h16[s] ? (dy < 16) : (dy < 8)) begin
        if (hits.size() < MAX_SPR) hits.push_back(s);
        else exp_ovf = 1'b1;
      end
    end
    for (int k = 0; k < hits.size(); k++) begin
      int s;
      s       = hits[k];
      dy      = ly - t_y[s];
      e.x     = t_x[s];
      e.row   = dy[2:0] ^ {3{t_vf[s]}};
      e.idx   = t_idx[s] + (t_h16[s] ? {9'd0, dy[3] ^ t_vf[s]} : 10'd0);
      e.pal   = t_pal[s];
      e.pri   = t_pri[s];
      e.hflip = t_hf[s];
      e.last  = (k == hits.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  // Pulse line_start; returns at the negedge of cycle 1 after the pulse.
  task automatic start_line(input logic [7:0] ly);
    @(negedge clk);
    line_start = 1'b1;
    line_y     = ly;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Drives out_ready, pops the scoreboard on each handshake, checks stall
  // stability, first-valid cycle, done cycle and final state.
  task automatic consume(input int ready_pct, input int exp_first, input int exp_done);
    int   cyc, first, done_cyc;
    bit   seen_done, stalled;
    ent_t cur, prev, e;
    cyc = 1; first = 0; done_cyc = 0; seen_done = 0; stalled = 0; prev = '0;
    while (!seen_done && cyc < 3000) begin
      cur = cur_ent();
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        out_ready = 1'b0;
        check("valid_at_done", 32'(out_valid), 32'd0);
      end else begin
        if (out_valid && first == 0) first = cyc;
        if (out_valid && stalled) check("stall_stable", 32'(cur), 32'(prev));
        out_ready = ($urandom_range(0, 99) < ready_pct);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(cur), 32'd0);
            n_fail += (cur == '0) ? 1 : 0;
          end else begin
            e = exp_q.pop_front();
            check("entry", 32'(cur), 32'(e));
          end
          stalled = 0;
        end else begin
          stalled = out_valid;
        end
        prev = cur;
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", 32'(seen_done), 32'd1);
    check("first_valid_cycle", 32'(first), 32'(exp_first));
    if (exp_done > 0) check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("overflow_at_done", 32'(overflow), 32'(exp_ovf));
    exp_q.delete();
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs[10];
    ent_t e;
    ent_t held;
    int   bad;

    //        ly     y     h16   vf    idx      vis   row   eidx
    vecs[0] = '{8'd20, 8'd15,  1'b0, 1'b0, 10'd50,   1'b1, 3'd5, 10'd50};
    vecs[1] = '{8'd20, 8'd20,  1'b1, 1'b1, 10'd100,  1'b1, 3'd7, 10'd101};
    vecs[2] = '{8'd3,  8'd250, 1'b1, 1'b0, 10'd200,  1'b1, 3'd1, 10'd201};
    vecs[3] = '{8'd3,  8'd250, 1'b0, 1'b0, 10'd200,  1'b0, 3'd0, 10'd0};
    vecs[4] = '{8'd10, 8'd3,   1'b0, 1'b1, 10'd7,    1'b1, 3'd0, 10'd7};
    vecs[5] = '{8'd10, 8'd2,   1'b0, 1'b0, 10'd7,    1'b0, 3'd0, 10'd0};
    vecs[6] = '{8'd10, 8'd0,   1'b1, 1'b1, 10'd1023, 1'b1, 3'd5, 10'd1023};
    vecs[7] = '{8'd10, 8'd255, 1'b1, 1'b0, 10'd1023, 1'b1, 3'd3, 10'd0};
    vecs[8] = '{8'd10, 8'd250, 1'b1, 1'b0, 10'd5,    1'b0, 3'd0, 10'd0};
    vecs[9] = '{8'd0,  8'd241, 1'b1, 1'b1, 10'd9,    1'b1, 3'd0, 10'd9};

    set_offline(8'd0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_spr_sel", 32'(spr_sel), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fields", 32'(cur_ent()), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single sprite (number 7) per vector, hand-computed expectations.
    for (int i = 0; i < 10; i++) begin
      set_offline(vecs[i].ly);
      t_y[7] = vecs[i].y; t_h16[7] = vecs[i].h16; t_vf[7] = vecs[i].vflip;
      t_idx[7] = vecs[i].idx; t_x[7] = 9'(i * 53 + 3); t_pal[7] = 2'(i);
      t_pri[7] = i[0]; t_hf[7] = i[1];
      exp_ovf = 1'b0;
      if (vecs[i].vis) begin
        e = '{9'(i * 53 + 3), vecs[i].eidx, vecs[i].row, 2'(i), i[0], i[1], 1'b1};
        exp_q.push_back(e);
      end
      start_line(vecs[i].ly);
      consume(60, vecs[i].vis ? 65 : 0, vecs[i].vis ? 0 : 65);
    end

    // Two sprites on line 20: order, row, idx increment, last flag, latency.
    set_offline(8'd20);
    t_y[5] = 8'd15; t_h16[5] = 1'b0; t_vf[5] = 1'b0; t_idx[5] = 10'd33;
    t_x[5] = 9'd300; t_pal[5] = 2'd2; t_pri[5] = 1'b1; t_hf[5] = 1'b0;
    t_y[9] = 8'd20; t_h16[9] = 1'b1; t_vf[9] = 1'b1; t_idx[9] = 10'd100;
    t_x[9] = 9'd17; t_pal[9] = 2'd1; t_pri[9] = 1'b0; t_hf[9] = 1'b1;
    exp_q.push_back('{9'd300, 10'd33, 3'd5, 2'd2, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{9'd17, 10'd101, 3'd7, 2'd1, 1'b0, 1'b1, 1'b1});
    exp_ovf = 1'b0;
    start_line(8'd20);
    consume(100, 65, 0);

    // All 64 visible: first MAX_SPR kept, overflow held into IDLE.
    for (int s = 0; s < 64; s++) begin
      t_y[s] = 8'd100 - 8'($urandom_range(0, 7));
      t_h16[s] = 1'($urandom);
    end
    model_line(8'd100);
    start_line(8'd100);
    consume(70, 65, 0);
    repeat (5) @(negedge clk);
    check("overflow_held_idle", 32'(overflow), 32'd1);

    // Empty line: done at cycle 65, overflow cleared, spr_sel parked at 63.
    set_offline(8'd200);
    model_line(8'd200);
    start_line(8'd200);
    consume(50, 0, 65);
    check("spr_sel_parked", 32'(spr_sel), 32'd63);

    // Random tables and random back-pressure.
    for (int n = 0; n < 6; n++) begin
      logic [7:0] ly;
      ly = 8'($urandom);
      set_offline(ly);
      for (int s = 0; s < 64; s++) begin
        t_y[s]   = ly - 8'($urandom_range(0, (n < 3) ? 40 : 120));
        t_h16[s] = 1'($urandom);
      end
      model_line(ly);
      start_line(ly);
      consume(30 + n * 10, (exp_q.size() > 0) ? 65 : 0, (exp_q.size() > 0) ? 0 : 65);
    end

    // line_start during a stalled EMIT abandons the list.
    for (int s = 0; s < 64; s++) t_y[s] = 8'd100;
    start_line(8'd100);
    out_ready = 1'b0;
    repeat (64) @(negedge clk);
    check("emit_valid", 32'(out_valid), 32'd1);
    check("emit_overflow", 32'(overflow), 32'd1);
    held = cur_ent();
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (cur_ent() != held || done) bad++;
    end
    check("stalled_hold", 32'(bad), 32'd0);
    set_offline(8'd40);
    t_y[3] = 8'd38; t_y[60] = 8'd33;
    model_line(8'd40);
    line_start = 1'b1;
    line_y     = 8'd40;
    @(negedge clk);
    line_start = 1'b0;
    check("restart_valid", 32'(out_valid), 32'd0);
    check("restart_sel", 32'(spr_sel), 32'd0);
    check("restart_ovf", 32'(overflow), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    consume(50, 65, 0);

    // Reset mid-SCAN: outputs return to reset values, no done afterwards.
    for (int s = 0; s < 64; s++) t_y[s] = 8'd77;
    start_line(8'd77);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_scan_busy", 32'(busy), 32'd0);
    check("rst_scan_sel", 32'(spr_sel), 32'd0);
    check("rst_scan_out", 32'({out_valid, overflow, done, cur_ent()}), 32'd0);
    reset = 1'b1;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (done || out_valid || busy) bad++;
    end
    check("no_done_after_rst", 32'(bad), 32'd0);

    // Reset wins over a simultaneous line_start.
    reset = 1'b0;
    line_start = 1'b1;
    @(negedge clk);
    check("rst_over_start", 32'(busy), 32'd0);
    reset = 1'b1;
    line_start = 1'b0;
    @(negedge clk);
    check("rst_over_start_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_eval.md
SPRITE_EVAL -- requirements
Module: sprite_eval

Interface
REQ-001 Parameter MAX_SPR, default 16, sets the per-line sprite list depth (range 1..64).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (reset=0 asserts).
REQ-004 line_start  input  1  single-cycle pulse; starts evaluation of line line_y.
REQ-005 line_y  input  8  line to evaluate; sampled on line_start.
REQ-006 spr_sel  output  6  attribute-table read address; data returns combinationally in the same cycle.
REQ-007 spr_x  input  9  X of the selected sprite.
REQ-008 spr_y  input  8  Y of the selected sprite.
REQ-009 spr_idx  input  10  tile index of the selected sprite.
REQ-010 spr_priority, spr_h16, spr_vflip, spr_hflip  input  1 each  attributes of the selected sprite.
REQ-011 spr_palette  input  2  palette of the selected sprite.
REQ-012 out_valid  output  1  list entry presented.
REQ-013 out_ready  input  1  consumer accepts the entry when out_valid && out_ready.
REQ-014 out_x 9, out_idx 10, out_row 3, out_palette 2, out_priority 1, out_hflip 1, out_last 1  outputs  fields of the presented entry.
REQ-015 busy  output  1  high in SCAN or EMIT.
REQ-016 overflow  output  1  more than MAX_SPR sprites matched the current line.
REQ-017 done  output  1  one-cycle pulse when evaluation of a line completes.

Function
REQ-018 FSM states: IDLE, SCAN, EMIT.
REQ-019 line_start in any state clears the list, count and overflow, latches line_y, sets spr_sel=0 and enters SCAN next cycle; an in-progress scan or emit is abandoned with no done pulse.
REQ-020 SCAN evaluates one sprite per cycle: cycle k after line_start (k=1..64) evaluates sprite k-1 at spr_sel=k-1.
REQ-021 dy = (latched_y - spr_y) mod 256 (8-bit wrap); the sprite is visible iff dy < 16 when spr_h16=1, else iff dy < 8.
REQ-022 A visible sprite is appended at the write pointer when count < MAX_SPR; when count = MAX_SPR, overflow is set and the sprite is dropped.
REQ-023 Stored fields: out_x=spr_x; out_row=dy[2:0] XOR {3{spr_vflip}}; out_idx=spr_idx + (spr_h16 ? (dy[3] XOR spr_vflip) : 0), 10-bit wrap; palette, priority and hflip are copied.
REQ-024 After sprite 63: if count>0 go to EMIT; otherwise pulse done and go to IDLE.
REQ-025 EMIT presents entries in ascending sprite-number order; out_valid stays high and the fields stay stable until accepted; out_last=1 only on entry count-1.
REQ-026 On acceptance of the entry with out_last=1: out_valid=0 next cycle, done pulses in that cycle, state goes to IDLE.
REQ-027 out_valid=0 outside EMIT; out_ready is ignored outside EMIT.
REQ-028 overflow holds its value through EMIT and IDLE until the next line_start or reset.
REQ-029 spr_sel holds at 63 after SCAN until the next line_start.

Reset
REQ-030 While reset=0: state=IDLE, spr_sel=0, count=0, out_valid=0, out_last=0, busy=0, overflow=0, done=0; all out_* data fields are 0.
REQ-031 Reset takes priority over line_start in the same cycle; reset during SCAN or EMIT discards the list.

Verification
REQ-032 line_y=20; sprite 5 at y=15, h16=0 and sprite 9 at y=20, h16=1, vflip=1, idx=100; all others off-line -> two entries in order: (sprite 5: row 5, idx unchanged), then (sprite 9: row 7, idx=101, out_last=1); first out_valid 65 cycles after line_start.
REQ-033 line_y=3, sprite at y=250, h16=1 (dy=9) -> visible, row=1, idx+1; y=250 with h16=0 -> not visible.
REQ-034 All 64 sprites visible, MAX_SPR=16 -> exactly 16 entries (sprites 0..15), overflow=1 until the next line_start.
REQ-035 No sprites visible -> no out_valid; done pulses exactly 65 cycles after line_start; busy low afterwards.
REQ-036 out_ready toggled randomly during EMIT -> each entry accepted exactly once, fields stable while stalled; then line_start mid-EMIT -> out_valid drops next cycle and the scan restarts at spr_sel=0 with overflow cleared.
REQ-037 reset=0 asserted mid-SCAN -> every output at its REQ-030 value on the next cycle, and no done pulse occurs.
